// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state encoding and owner IDs.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational 2-way owner pick. MEM_ARB_RR_EN selects round-robin on
// simultaneous requests; otherwise DM has fixed priority over IF.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last,
    output logic owner
);

`ifdef MEM_ARB_RR_EN
    // Simultaneous requests go to the port that was not served last.
    assign owner = (if_req && dm_req) ? ~last : (dm_req ? OWN_DM : OWN_IF);
`else
    logic unused_last;
    assign unused_last = last;
    assign owner = (dm_req || !if_req) ? OWN_DM : OWN_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between fetch (IF) and data (DM) ports.
// Optional round-robin arbitration with `define MEM_ARB_RR_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    arb_state_t        state, state_nx;
    logic              owner, grant_owner, last_own, kill;
    logic              grant, err_now, to_resp, resp_owner;
    logic              flush_hit, killed_nx, load_ack;
    logic [ADDR_W-1:0] req_addr;

    arb_pick u_pick (
        .if_req (if_req),
        .dm_req (dm_req),
        .last   (last_own),
        .owner  (grant_owner)
    );

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last_own <= OWN_IF;
        else if (grant) last_own <= grant_owner;
    end
`else
    assign last_own = OWN_IF;
`endif

    assign grant      = (state == IDLE) && (if_req || dm_req);
    assign req_addr   = (grant_owner == OWN_DM) ? dm_addr : if_addr;
    assign err_now    = grant && req_addr[0];
    assign resp_owner = (state == IDLE) ? grant_owner : owner;
    assign flush_hit  = if_flush && (state != IDLE) && (owner == OWN_IF);
    // Include a flush arriving in the same cycle the response is being registered.
    assign killed_nx  = kill || flush_hit;
    assign load_ack   = (state == WAIT) && mem_ack && !mem_wr;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (if_req || dm_req) state_nx = req_addr[0] ? RESP : ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (mem_ack) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign to_resp = (state_nx == RESP) && (state != RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            kill      <= 1'b0;
            busy      <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            dm_done   <= 1'b0;
            dm_err    <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            state  <= state_nx;
            busy   <= (state_nx != IDLE);
            mem_en <= (state_nx == ISSUE);
            if (grant) begin
                owner     <= grant_owner;
                mem_addr  <= req_addr;
                mem_wr    <= (grant_owner == OWN_DM) && dm_wr;
                mem_wdata <= (grant_owner == OWN_DM) ? dm_wdata : '0;
            end
            if (state_nx == IDLE) kill <= 1'b0;
            else if (flush_hit)   kill <= 1'b1;
            if_done  <= to_resp && (resp_owner == OWN_IF) && !killed_nx;
            if_err   <= to_resp && (resp_owner == OWN_IF) && !killed_nx && err_now;
            dm_done  <= to_resp && (resp_owner == OWN_DM);
            dm_err   <= to_resp && (resp_owner == OWN_DM) && err_now;
            if_rdata <= (load_ack && owner == OWN_IF && !killed_nx) ? mem_rdata : '0;
            dm_rdata <= (load_ack && owner == OWN_DM) ? mem_rdata : '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a variable-latency memory model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_done, if_err;
    logic        dm_req = 1'b0, dm_wr = 1'b0;
    logic [15:0] dm_addr = '0, dm_wdata = '0;
    logic [15:0] dm_rdata;
    logic        dm_done, dm_err;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        busy;

    int n_chk = 0, n_fail = 0;

    int          ack_lat = 1;
    logic [15:0] rd_val = '0;
    logic [15:0] pend_data = '0;
    int          pend_cnt = 0;
    bit          pend = 1'b0;
    int          en_cnt = 0, if_done_cnt = 0, dm_done_cnt = 0;
    logic        m_wr = 1'b0;
    logic [15:0] m_addr = '0, m_wdata = '0;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: acks ack_lat cycles after the mem_en cycle, independent of arbiter reset.
    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = pend_data;
                pend      = 1'b0;
            end
        end
        if (mem_en) begin
            en_cnt++;
            m_addr    = mem_addr;
            m_wr      = mem_wr;
            m_wdata   = mem_wdata;
            pend      = 1'b1;
            pend_cnt  = ack_lat;
            pend_data = rd_val;
        end
        if (if_done) if_done_cnt++;
        if (dm_done) dm_done_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits for the next done pulse on either port; lat = -1 on timeout.
    task automatic wait_any(output logic got_dm, output int lat,
                            output logic [15:0] rd, output logic er);
        got_dm = 1'b0; lat = 0; rd = '0; er = 1'b0;
        repeat (40) begin
            @(negedge clk);
            lat++;
            if (dm_done || if_done) begin
                got_dm = dm_done;
                rd     = dm_done ? dm_rdata : if_rdata;
                er     = dm_done ? dm_err : if_err;
                return;
            end
        end
        lat = -1;
    endtask

    logic        w_dm, w_er;
    int          w_lat, e0, c0;
    logic [15:0] w_rd;
    int          exp_own[4];

    initial begin
`ifdef MEM_ARB_RR_EN
        exp_own = '{1, 0, 1, 0};
`else
        exp_own = '{1, 1, 1, 1};
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_done", {if_done, dm_done}, 0);
        chk("rst_rdata", {if_rdata, dm_rdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // IF load, ack 2 cycles after mem_en
        ack_lat = 2; rd_val = 16'hA5A5; e0 = en_cnt;
        if_req = 1'b1; if_addr = 16'h0040;
        wait_any(w_dm, w_lat, w_rd, w_er);
        if_req = 1'b0;
        chk("if_load_lat", w_lat, 4);
        chk("if_load_port", w_dm, 0);
        chk("if_load_data", w_rd, 16'hA5A5);
        chk("if_load_err", w_er, 0);
        chk("if_load_en_cnt", en_cnt - e0, 1);
        chk("if_load_addr", m_addr, 16'h0040);
        @(negedge clk);
        chk("if_load_idle", busy, 0);

        // Both ports held high: grant sequence
        ack_lat = 1; rd_val = 16'h1111;
        if_req = 1'b1; if_addr = 16'h0100;
        dm_req = 1'b1; dm_addr = 16'h0200; dm_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_any(w_dm, w_lat, w_rd, w_er);
            chk($sformatf("prio_owner%0d", i), w_dm, exp_own[i]);
            chk($sformatf("prio_lat%0d", i), w_lat, (i == 0) ? 3 : 4);
        end
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);

        // Store
        rd_val = 16'hFFFF; e0 = en_cnt;
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h1000; dm_wdata = 16'h1234;
        wait_any(w_dm, w_lat, w_rd, w_er);
        dm_req = 1'b0; dm_wr = 1'b0;
        chk("st_lat", w_lat, 3);
        chk("st_port", w_dm, 1);
        chk("st_rdata", w_rd, 0);
        chk("st_mem_wr", m_wr, 1);
        chk("st_mem_addr", m_addr, 16'h1000);
        chk("st_mem_wdata", m_wdata, 16'h1234);
        @(negedge clk);

        // Unaligned DM and IF
        e0 = en_cnt;
        dm_req = 1'b1; dm_addr = 16'h0003;
        wait_any(w_dm, w_lat, w_rd, w_er);
        dm_req = 1'b0;
        chk("unal_dm_lat", w_lat, 1);
        chk("unal_dm_err", {w_dm, w_er}, 2'b11);
        chk("unal_dm_rdata", w_rd, 0);
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0041;
        wait_any(w_dm, w_lat, w_rd, w_er);
        if_req = 1'b0;
        chk("unal_if_err", {w_dm, w_er, w_lat[3:0]}, {2'b01, 4'd1});
        chk("unal_no_mem_en", en_cnt - e0, 0);
        @(negedge clk);

        // Flush during WAIT of an IF fetch
        ack_lat = 3; rd_val = 16'h7777; e0 = en_cnt; c0 = if_done_cnt;
        if_req = 1'b1; if_addr = 16'h0080;
        @(negedge clk);
        @(negedge clk);
        if_flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        if_flush = 1'b0;
        repeat (8) @(negedge clk);
        chk("flush_no_done", if_done_cnt - c0, 0);
        chk("flush_en_cnt", en_cnt - e0, 1);
        chk("flush_idle", busy, 0);
        ack_lat = 1; rd_val = 16'h5A5A;
        if_req = 1'b1; if_addr = 16'h0082;
        wait_any(w_dm, w_lat, w_rd, w_er);
        if_req = 1'b0;
        chk("post_flush_lat", w_lat, 3);
        chk("post_flush_data", w_rd, 16'h5A5A);
        @(negedge clk);

        // Flush while DM owns memory has no effect
        ack_lat = 2; rd_val = 16'h3C3C;
        dm_req = 1'b1; dm_addr = 16'h0300;
        @(negedge clk);
        @(negedge clk);
        if_flush = 1'b1;
        @(negedge clk);
        if_flush = 1'b0;
        wait_any(w_dm, w_lat, w_rd, w_er);
        dm_req = 1'b0;
        chk("dm_flush_done", w_dm, 1);
        chk("dm_flush_data", w_rd, 16'h3C3C);
        @(negedge clk);

        // Reset in WAIT, stale ack arrives while idle
        ack_lat = 4; rd_val = 16'hDEAD; c0 = dm_done_cnt;
        dm_req = 1'b1; dm_addr = 16'h0020;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; dm_req = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mem_en", mem_en, 0);
        chk("arst_mem_addr", mem_addr, 0);
        chk("arst_done", {if_done, dm_done}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("stale_ack_no_done", dm_done_cnt - c0, 0);
        chk("stale_ack_idle", busy, 0);
        ack_lat = 2; rd_val = 16'hBEEF;
        dm_req = 1'b1; dm_addr = 16'h0022;
        wait_any(w_dm, w_lat, w_rd, w_er);
        dm_req = 1'b0;
        chk("post_rst_lat", w_lat, 4);
        chk("post_rst_data", w_rd, 16'hBEEF);
        chk("post_rst_addr", m_addr, 16'h0022);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
